// File: rtl/axis_frame_unpacker.sv
// axis_frame_unpacker
//
// AXI-stream slave that collects 64-word frames of sign-extended 32-bit
// coefficients, narrows each word to 12-bit signed, and replays the frame
// as eight 8-lane rows on a valid/ready row interface.
//
// Build option: AXIS_UNPACK_SAT_EN
//   defined   - words are clamped to [-2048, 2047]; o_sat flags any clamp.
//   undefined - words are truncated to data[11:0]; o_sat is tied low.
//
// Ports:
//   i_clk, i_rst                 clock, async active-low reset
//   s_axis_valid/ready/data/last AXI-stream word input
//   o_row_data1..8, o_row_idx    current row lanes and row number
//   o_row_valid, i_row_ready     row handshake
//   o_frame_err                  one-cycle pulse on a short or long frame
//   o_err_cnt                    saturating framing-error count
//   o_sat                        sticky clamp flag
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FILL  | accepting words into the buffer
// ST_DRAIN | emitting rows 0..7, input stalled
// ST_SYNC  | discarding the tail of a long frame until its last word

module axis_frame_unpacker #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 s_axis_valid,
  output logic                 s_axis_ready,
  input  logic [31:0]          s_axis_data,
  input  logic                 s_axis_last,
  output logic [11:0]          o_row_data1,
  output logic [11:0]          o_row_data2,
  output logic [11:0]          o_row_data3,
  output logic [11:0]          o_row_data4,
  output logic [11:0]          o_row_data5,
  output logic [11:0]          o_row_data6,
  output logic [11:0]          o_row_data7,
  output logic [11:0]          o_row_data8,
  output logic [2:0]           o_row_idx,
  output logic                 o_row_valid,
  input  logic                 i_row_ready,
  output logic                 o_frame_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic                 o_sat
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SYNC  = 2'd2
  } state_t;

  state_t               state;
  logic [5:0]           wr_pt;
  logic [2:0]           rd_row;
  logic                 sync_pend;
  logic [11:0]          mem [64];
  logic [11:0]          row_q [8];
  logic [11:0]          narrow_word;
  logic                 narrow_clamp;
  logic                 word_acc;
  logic                 row_acc;
  logic [2:0]           next_row;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;

  assign word_acc    = s_axis_valid & s_axis_ready;
  assign row_acc     = o_row_valid & i_row_ready;
  // Row to present after this edge: row 0 when a frame completes, else the successor.
  assign next_row    = (state == ST_DRAIN) ? rd_row + 3'd1 : 3'd0;
  assign err_cnt_nxt = (&o_err_cnt) ? o_err_cnt : o_err_cnt + 1'b1;

`ifdef AXIS_UNPACK_SAT_EN
  always_comb begin
    narrow_word  = s_axis_data[11:0];
    narrow_clamp = 1'b0;
    if ($signed(s_axis_data) > 32'sd2047) begin
      narrow_word  = 12'h7FF;
      narrow_clamp = 1'b1;
    end else if ($signed(s_axis_data) < -32'sd2048) begin
      narrow_word  = 12'h800;
      narrow_clamp = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi    = ^s_axis_data[31:12];
  assign narrow_word  = s_axis_data[11:0];
  assign narrow_clamp = 1'b0;
`endif

  // Buffer contents survive reset as don't-care, so no reset here.
  always_ff @(posedge i_clk) begin
    if (state == ST_FILL && word_acc) begin
      mem[wr_pt] <= narrow_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= ST_FILL;
      wr_pt        <= '0;
      rd_row       <= '0;
      sync_pend    <= 1'b0;
      s_axis_ready <= 1'b0;
      o_row_valid  <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_cnt    <= '0;
      o_sat        <= 1'b0;
      for (int l = 0; l < 8; l++) row_q[l] <= '0;
    end else begin
      o_frame_err <= 1'b0;
      case (state)
        ST_FILL: begin
          // First cycle after reset release: ready comes up here.
          s_axis_ready <= 1'b1;
          if (word_acc) begin
            if (narrow_clamp) o_sat <= 1'b1;
            wr_pt <= wr_pt + 6'd1;
            if (wr_pt == 6'd63) begin
              // Word 63 is written this same edge; row 0 is already complete.
              state        <= ST_DRAIN;
              s_axis_ready <= 1'b0;
              o_row_valid  <= 1'b1;
              rd_row       <= 3'd0;
              for (int l = 0; l < 8; l++) row_q[l] <= mem[{next_row, 3'(l)}];
              if (!s_axis_last) begin
                sync_pend   <= 1'b1;
                o_frame_err <= 1'b1;
                o_err_cnt   <= err_cnt_nxt;
              end
            end else if (s_axis_last) begin
              wr_pt       <= 6'd0;
              o_frame_err <= 1'b1;
              o_err_cnt   <= err_cnt_nxt;
            end
          end
        end
        ST_DRAIN: begin
          if (row_acc) begin
            if (rd_row == 3'd7) begin
              rd_row       <= 3'd0;
              o_row_valid  <= 1'b0;
              s_axis_ready <= 1'b1;
              sync_pend    <= 1'b0;
              state        <= sync_pend ? ST_SYNC : ST_FILL;
            end else begin
              rd_row <= next_row;
              for (int l = 0; l < 8; l++) row_q[l] <= mem[{next_row, 3'(l)}];
            end
          end
        end
        ST_SYNC: begin
          s_axis_ready <= 1'b1;
          if (word_acc && s_axis_last) state <= ST_FILL;
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign o_row_idx   = rd_row;
  assign o_row_data1 = row_q[0];
  assign o_row_data2 = row_q[1];
  assign o_row_data3 = row_q[2];
  assign o_row_data4 = row_q[3];
  assign o_row_data5 = row_q[4];
  assign o_row_data6 = row_q[5];
  assign o_row_data7 = row_q[6];
  assign o_row_data8 = row_q[7];

endmodule

// File: tb/tb_axis_frame_unpacker.sv
// Directed bench for axis_frame_unpacker. Works with or without
// AXIS_UNPACK_SAT_EN defined.

module tb_axis_frame_unpacker;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic [31:0] s_axis_data;
  logic        s_axis_last;
  logic [11:0] lane [8];
  logic [2:0]  o_row_idx;
  logic        o_row_valid;
  logic        i_row_ready;
  logic        o_frame_err;
  logic [7:0]  o_err_cnt;
  logic        o_sat;

  int          checks = 0;
  int          errors = 0;
  int          words [80];
  logic [11:0] exp;

  always #5 i_clk = ~i_clk;

  axis_frame_unpacker #(.ERR_CNT_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
    .o_row_data1  (lane[0]),
    .o_row_data2  (lane[1]),
    .o_row_data3  (lane[2]),
    .o_row_data4  (lane[3]),
    .o_row_data5  (lane[4]),
    .o_row_data6  (lane[5]),
    .o_row_data7  (lane[6]),
    .o_row_data8  (lane[7]),
    .o_row_idx    (o_row_idx),
    .o_row_valid  (o_row_valid),
    .i_row_ready  (i_row_ready),
    .o_frame_err  (o_frame_err),
    .o_err_cnt    (o_err_cnt),
    .o_sat        (o_sat)
  );

  function automatic logic [11:0] nrw(input int v);
`ifdef AXIS_UNPACK_SAT_EN
    if (v > 2047) return 12'h7FF;
    if (v < -2048) return 12'h800;
`endif
    return 12'(v);
  endfunction

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic send_word(input int d, input logic l);
    int n = 0;
    s_axis_valid = 1'b1;
    s_axis_data  = 32'(d);
    s_axis_last  = l;
    while (!s_axis_ready && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready stayed %b, want 1", s_axis_ready);
    end else begin
      @(posedge i_clk); #1;
    end
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic send_words(input int n, input int last_idx);
    for (int k = 0; k < n; k++) send_word(words[k], k == last_idx);
  endtask

  task automatic apply_reset();
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0; i_row_ready = 1'b1;
    apply_reset();
    checks++;
    if ({s_axis_ready, o_row_valid, o_row_idx, o_frame_err, o_err_cnt, o_sat} !== '0 ||
        (lane[0] | lane[3] | lane[7]) !== 12'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b idx=%0d err=%b cnt=%0d sat=%b, want all 0",
               s_axis_ready, o_row_valid, o_row_idx, o_frame_err, o_err_cnt, o_sat);
    end
    @(posedge i_clk); #1;
    checks++;
    if (s_axis_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_rise: got %b, want 1", s_axis_ready);
    end
  endtask

  task automatic test_ramp();
    for (int k = 0; k < 64; k++) words[k] = k - 32;
    send_words(64, 63);
    checks++;
    if (s_axis_ready !== 1'b0) begin
      errors++; $display("FAIL ramp_ready_drop: got %b, want 0", s_axis_ready);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (o_row_valid !== 1'b1 || o_row_idx !== 3'(r)) begin
        errors++;
        $display("FAIL ramp_row_hdr r=%0d: got valid=%b idx=%0d, want valid=1 idx=%0d", r, o_row_valid, o_row_idx, r);
      end
      for (int l = 0; l < 8; l++) begin
        exp = 12'(8 * r + l - 32);
        checks++;
        if (lane[l] !== exp) begin
          errors++; $display("FAIL ramp_lane r=%0d l=%0d: got %h, want %h", r, l + 1, lane[l], exp);
        end
      end
      @(posedge i_clk); #1;
    end
    checks++;
    if (o_row_valid !== 1'b0 || s_axis_ready !== 1'b1) begin
      errors++; $display("FAIL ramp_after: got valid=%b ready=%b, want valid=0 ready=1", o_row_valid, s_axis_ready);
    end
    checks++;
    if (o_sat !== 1'b0) begin
      errors++; $display("FAIL ramp_no_sat: got %b, want 0", o_sat);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 64; k++) words[k] = 3 * k - 90;
    send_words(64, 63);
    s_axis_valid = 1'b1; s_axis_data = 32'h123;
    for (int r = 0; r < 8; r++) begin
      if (r == 3) begin
        i_row_ready = 1'b0;
        repeat (5) begin
          @(posedge i_clk); #1;
          exp = nrw(words[24 + 7]);
          checks++;
          if (o_row_valid !== 1'b1 || o_row_idx !== 3'd3 || lane[0] !== nrw(words[24]) || lane[7] !== exp) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b idx=%0d l1=%h l8=%h, want 1 3 %h %h",
                     o_row_valid, o_row_idx, lane[0], lane[7], nrw(words[24]), exp);
          end
        end
        i_row_ready = 1'b1;
      end
      checks++;
      if (o_row_valid !== 1'b1 || o_row_idx !== 3'(r) || s_axis_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_row_hdr r=%0d: got valid=%b idx=%0d ready=%b, want 1 %0d 0", r, o_row_valid, o_row_idx, s_axis_ready, r);
      end
      for (int l = 0; l < 8; l++) begin
        exp = nrw(words[8 * r + l]);
        checks++;
        if (lane[l] !== exp) begin
          errors++; $display("FAIL bp_lane r=%0d l=%0d: got %h, want %h", r, l + 1, lane[l], exp);
        end
      end
      if (r == 7) s_axis_valid = 1'b0;
      @(posedge i_clk); #1;
    end
    checks++;
    if (o_row_valid !== 1'b0 || s_axis_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after: got valid=%b ready=%b, want 0 1", o_row_valid, s_axis_ready);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 64; k++) words[k] = k;
    words[0] = 5000; words[1] = -5000; words[2] = 2047;
    send_words(64, 63);
`ifdef AXIS_UNPACK_SAT_EN
    checks++;
    if (lane[0] !== 12'h7FF || lane[1] !== 12'h800 || lane[2] !== 12'h7FF || o_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_clamp: got %h %h %h sat=%b, want 7ff 800 7ff sat=1", lane[0], lane[1], lane[2], o_sat);
    end
`else
    checks++;
    if (lane[0] !== 12'h388 || lane[1] !== 12'hC78 || lane[2] !== 12'h7FF || o_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_trunc: got %h %h %h sat=%b, want 388 c78 7ff sat=0", lane[0], lane[1], lane[2], o_sat);
    end
`endif
    checks++;
    if (lane[3] !== 12'd3 || lane[7] !== 12'd7) begin
      errors++; $display("FAIL sat_plain: got %h %h, want 003 007", lane[3], lane[7]);
    end
    repeat (8) @(posedge i_clk);
    #1;
    checks++;
    if (o_row_valid !== 1'b0 || s_axis_ready !== 1'b1) begin
      errors++; $display("FAIL sat_after: got valid=%b ready=%b, want 0 1", o_row_valid, s_axis_ready);
    end
  endtask

  task automatic test_short_frame();
    int seen_valid = 0;
    for (int k = 0; k < 11; k++) words[k] = 1000 + k;
    send_words(11, 10);
    checks++;
    if (o_frame_err !== 1'b1 || o_err_cnt !== 8'd1) begin
      errors++; $display("FAIL short_err: got err=%b cnt=%0d, want 1 1", o_frame_err, o_err_cnt);
    end
    repeat (10) begin
      @(posedge i_clk); #1;
      if (o_row_valid) seen_valid++;
    end
    checks++;
    if (o_frame_err !== 1'b0 || seen_valid != 0 || s_axis_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_quiet: got err=%b valid_cycles=%0d ready=%b, want 0 0 1", o_frame_err, seen_valid, s_axis_ready);
    end
    for (int k = 0; k < 64; k++) words[k] = 50 - k;
    send_words(64, 63);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (o_row_valid !== 1'b1 || o_row_idx !== 3'(r)) begin
        errors++; $display("FAIL short_next_hdr r=%0d: got valid=%b idx=%0d", r, o_row_valid, o_row_idx);
      end
      for (int l = 0; l < 8; l++) begin
        exp = nrw(words[8 * r + l]);
        checks++;
        if (lane[l] !== exp) begin
          errors++; $display("FAIL short_next_lane r=%0d l=%0d: got %h, want %h", r, l + 1, lane[l], exp);
        end
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_long_frame();
    apply_reset();
    @(posedge i_clk); #1;
    for (int k = 0; k < 70; k++) words[k] = k + 7;
    send_words(64, 69);
    checks++;
    if (o_frame_err !== 1'b1 || o_err_cnt !== 8'd1 || o_row_valid !== 1'b1) begin
      errors++;
      $display("FAIL long_err: got err=%b cnt=%0d valid=%b, want 1 1 1", o_frame_err, o_err_cnt, o_row_valid);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (o_row_valid !== 1'b1 || o_row_idx !== 3'(r)) begin
        errors++; $display("FAIL long_hdr r=%0d: got valid=%b idx=%0d", r, o_row_valid, o_row_idx);
      end
      for (int l = 0; l < 8; l++) begin
        exp = nrw(words[8 * r + l]);
        checks++;
        if (lane[l] !== exp) begin
          errors++; $display("FAIL long_lane r=%0d l=%0d: got %h, want %h", r, l + 1, lane[l], exp);
        end
      end
      @(posedge i_clk); #1;
    end
    for (int k = 64; k < 70; k++) send_word(words[k], k == 69);
    checks++;
    if (o_row_valid !== 1'b0 || s_axis_ready !== 1'b1) begin
      errors++; $display("FAIL long_discard: got valid=%b ready=%b, want 0 1", o_row_valid, s_axis_ready);
    end
    for (int k = 0; k < 64; k++) words[k] = 200 - 2 * k;
    send_words(64, 63);
    checks++;
    if (o_frame_err !== 1'b0 || o_err_cnt !== 8'd1) begin
      errors++; $display("FAIL long_next_err: got err=%b cnt=%0d, want 0 1", o_frame_err, o_err_cnt);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (o_row_valid !== 1'b1 || o_row_idx !== 3'(r)) begin
        errors++; $display("FAIL long_next_hdr r=%0d: got valid=%b idx=%0d", r, o_row_valid, o_row_idx);
      end
      for (int l = 0; l < 8; l++) begin
        exp = nrw(words[8 * r + l]);
        checks++;
        if (lane[l] !== exp) begin
          errors++; $display("FAIL long_next_lane r=%0d l=%0d: got %h, want %h", r, l + 1, lane[l], exp);
        end
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 64; k++) words[k] = 5 * k - 150;
    send_words(64, 63);
    repeat (4) begin
      @(posedge i_clk); #1;
    end
    checks++;
    if (o_row_valid !== 1'b1 || o_row_idx !== 3'd4) begin
      errors++; $display("FAIL rst_pre: got valid=%b idx=%0d, want 1 4", o_row_valid, o_row_idx);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if ({s_axis_ready, o_row_valid, o_row_idx, o_frame_err, o_err_cnt, o_sat} !== '0 ||
        (lane[0] | lane[1] | lane[2] | lane[3] | lane[4] | lane[5] | lane[6] | lane[7]) !== 12'h0) begin
      errors++;
      $display("FAIL rst_async: got ready=%b valid=%b idx=%0d err=%b cnt=%0d sat=%b l1=%h, want all 0",
               s_axis_ready, o_row_valid, o_row_idx, o_frame_err, o_err_cnt, o_sat, lane[0]);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (s_axis_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready: got %b, want 1", s_axis_ready);
    end
    for (int k = 0; k < 64; k++) words[k] = 30 - k;
    send_words(64, 63);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (o_row_valid !== 1'b1 || o_row_idx !== 3'(r)) begin
        errors++; $display("FAIL rst_fresh_hdr r=%0d: got valid=%b idx=%0d", r, o_row_valid, o_row_idx);
      end
      for (int l = 0; l < 8; l++) begin
        exp = nrw(words[8 * r + l]);
        checks++;
        if (lane[l] !== exp) begin
          errors++; $display("FAIL rst_fresh_lane r=%0d l=%0d: got %h, want %h", r, l + 1, lane[l], exp);
        end
      end
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_saturation();
    test_short_frame();
    test_long_frame();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
